// File: rtl/plot_framebuffer.sv
// Pixel-plot sink: 160x120 framebuffer with a full-screen clear engine and a registered scanout read port.
// Optional build macro FB_PLOT_STATS_EN adds saturating accepted/dropped plot counters.
module plot_framebuffer #(
    parameter int WIDTH    = 160,
    parameter int HEIGHT   = 120,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          vga_x,
    input  logic [6:0]          vga_y,
    input  logic [COLOUR_W-1:0] vga_colour,
    input  logic                vga_plot,
    input  logic                clear_start,
    input  logic [COLOUR_W-1:0] clear_colour,
    output logic                clear_done,
    input  logic [7:0]          rd_x,
    input  logic [6:0]          rd_y,
    output logic [COLOUR_W-1:0] rd_colour,
    output logic [15:0]         plot_count,
    output logic [15:0]         drop_count,
    output logic [1:0]          dbg_state
);
    localparam int          NPIX      = WIDTH * HEIGHT;
    localparam logic [14:0] LAST_ADDR = 15'(NPIX - 1);
    localparam logic [14:0] W15       = 15'(WIDTH);
    localparam logic [7:0]  W8        = 8'(WIDTH);
    localparam logic [6:0]  H7        = 7'(HEIGHT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
        return 15'(y) * W15 + 15'(x);
    endfunction

    logic [COLOUR_W-1:0] mem [0:NPIX-1];

    logic [1:0]          state_q, state_d;
    logic [14:0]         clr_addr_q, clr_addr_d;
    logic [COLOUR_W-1:0] fill_q, fill_d;
    logic                in_valid_q;
    logic [14:0]         in_addr_q;
    logic [COLOUR_W-1:0] in_col_q;
    logic [COLOUR_W-1:0] rd_colour_q;

    logic                plot_onscreen, plot_accept, rd_onscreen;
    logic                plot_wr, clear_wr, wr_en;
    logic [14:0]         wr_addr;
    logic [COLOUR_W-1:0] wr_data;

    // Accept/drop is decided at capture time, so a plot taken on the IDLE->CLEAR edge still lands.
    assign plot_onscreen = (vga_x < W8) && (vga_y < H7);
    assign plot_accept   = vga_plot && plot_onscreen && (state_q != ST_CLEAR);
    assign rd_onscreen   = (rd_x < W8) && (rd_y < H7);

    always_ff @(posedge clk) begin
        if (rst) in_valid_q <= 1'b0;
        else     in_valid_q <= plot_accept;
    end

    always_ff @(posedge clk) begin
        in_addr_q <= pix_addr(vga_x, vga_y);
        in_col_q  <= vga_colour;
    end

    // A pending plot owns the single write port; the clear address simply holds for that cycle.
    assign plot_wr  = in_valid_q && !rst;
    assign clear_wr = (state_q == ST_CLEAR) && !plot_wr && !rst;
    assign wr_en    = plot_wr || clear_wr;
    assign wr_addr  = plot_wr ? in_addr_q : clr_addr_q;
    assign wr_data  = plot_wr ? in_col_q : fill_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst)              rd_colour_q <= '0;
        else if (rd_onscreen) rd_colour_q <= mem[pix_addr(rd_x, rd_y)];
        else                  rd_colour_q <= '0;
    end
    assign rd_colour = rd_colour_q;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        fill_d     = fill_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                    fill_d     = clear_colour;
                end
            end
            ST_CLEAR: begin
                if (!plot_wr) begin
                    clr_addr_d = 15'(clr_addr_q + 15'd1);
                    if (clr_addr_q == LAST_ADDR) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!clear_start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
            fill_q     <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            fill_q     <= fill_d;
        end
    end

    assign clear_done = (state_q == ST_DONE);
    assign dbg_state  = state_q;

`ifdef FB_PLOT_STATS_EN
    logic        plot_drop;
    logic [15:0] plot_cnt_q, drop_cnt_q;

    assign plot_drop = vga_plot && !plot_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            plot_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (plot_accept && plot_cnt_q != 16'hFFFF) plot_cnt_q <= plot_cnt_q + 16'd1;
            if (plot_drop && drop_cnt_q != 16'hFFFF)   drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end
    assign plot_count = plot_cnt_q;
    assign drop_count = drop_cnt_q;
`else
    assign plot_count = 16'd0;
    assign drop_count = 16'd0;
`endif
endmodule

// File: tb/tb_plot_framebuffer.sv
// Bench for plot_framebuffer: a pixel-array model with a per-cycle compare process plus directed scenarios.
module tb_plot_framebuffer;
    localparam int W    = 160;
    localparam int H    = 120;
    localparam int CW   = 3;
    localparam int NPIX = W * H;

    logic          clk;
    logic          rst;
    logic [7:0]    vga_x;
    logic [6:0]    vga_y;
    logic [CW-1:0] vga_colour;
    logic          vga_plot;
    logic          clear_start;
    logic [CW-1:0] clear_colour;
    logic          clear_done;
    logic [7:0]    rd_x;
    logic [6:0]    rd_y;
    logic [CW-1:0] rd_colour;
    logic [15:0]   plot_count;
    logic [15:0]   drop_count;
    logic [1:0]    dbg_state;

    plot_framebuffer #(.WIDTH(W), .HEIGHT(H), .COLOUR_W(CW)) dut (
        .clk(clk), .rst(rst),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .clear_start(clear_start), .clear_colour(clear_colour), .clear_done(clear_done),
        .rd_x(rd_x), .rd_y(rd_y), .rd_colour(rd_colour),
        .plot_count(plot_count), .drop_count(drop_count), .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // model state
    logic [CW-1:0] model_mem [NPIX];
    bit            model_known [NPIX];
    bit            in_clear;
    bit            pend_v;
    int            pend_a;
    logic [CW-1:0] pend_c;
    int            exp_plot, exp_drop;
    logic [CW:0]   exp_q[$];
    int            checks, failures;
    bit            started;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Model update at each active edge: read sees pre-edge contents, then last edge's plot lands.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.push_back({1'b1, {CW{1'b0}}});
            pend_v   = 0;
            exp_plot = 0;
            exp_drop = 0;
        end else begin
            if (int'(rd_x) < W && int'(rd_y) < H) begin
                int a;
                a = int'(rd_y) * W + int'(rd_x);
                exp_q.push_back({model_known[a] && !in_clear, model_mem[a]});
            end else begin
                exp_q.push_back({1'b1, {CW{1'b0}}});
            end
            if (pend_v) begin
                model_mem[pend_a]   = pend_c;
                model_known[pend_a] = 1;
            end
            pend_v = 0;
            if (vga_plot) begin
                if (int'(vga_x) < W && int'(vga_y) < H && !in_clear) begin
                    pend_v = 1;
                    pend_a = int'(vga_y) * W + int'(vga_x);
                    pend_c = vga_colour;
                    if (exp_plot < 65535) exp_plot++;
                end else begin
                    if (exp_drop < 65535) exp_drop++;
                end
            end
        end
    end

    // scoreboard compare on the inactive edge
    always @(negedge clk) begin
        if (started) begin
            if (exp_q.size() > 0) begin
                logic [CW:0] e;
                e = exp_q.pop_front();
                if (e[CW]) check("rd_colour", int'(rd_colour), int'(e[CW-1:0]));
            end
`ifdef FB_PLOT_STATS_EN
            check("plot_count", int'(plot_count), exp_plot);
            check("drop_count", int'(drop_count), exp_drop);
`else
            check("plot_count_tied", int'(plot_count), 0);
            check("drop_count_tied", int'(drop_count), 0);
`endif
        end
    end

    // driver tasks
    task automatic plot(input int x, input int y, input logic [CW-1:0] c);
        vga_x = 8'(x); vga_y = 7'(y); vga_colour = c; vga_plot = 1'b1;
        @(negedge clk);
        vga_plot = 1'b0;
    endtask

    task automatic read_px(input int x, input int y, output logic [CW-1:0] c);
        rd_x = 8'(x); rd_y = 7'(y);
        @(negedge clk);
        c = rd_colour;
    endtask

    task automatic do_clear(input logic [CW-1:0] c, input int n_stream, output int cycles);
        clear_colour = c;
        clear_start  = 1'b1;
        in_clear     = 1;
        cycles       = 0;
        while (!clear_done && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            if (cycles >= 100 && cycles < 100 + n_stream) begin
                vga_x = 8'(cycles - 100); vga_y = 7'd10; vga_colour = 3'b111; vga_plot = 1'b1;
            end else begin
                vga_plot = 1'b0;
            end
        end
        vga_plot = 1'b0;
        if (!clear_done) check("clear_done_timeout", 0, 1);
        for (int a = 0; a < NPIX; a++) begin
            model_mem[a]   = c;
            model_known[a] = 1;
        end
        in_clear = 0;
    endtask

    initial begin
        started = 0;
        @(posedge clk);
        #1 started = 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] c;
        int cyc, bad, ox, oy, crit;
        int qx[$], qy[$];
        checks = 0; failures = 0;
        in_clear = 0; pend_v = 0; exp_plot = 0; exp_drop = 0;
        for (int a = 0; a < NPIX; a++) model_known[a] = 0;
        rst = 1'b1; vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
        clear_start = 1'b0; clear_colour = '0; rd_x = '0; rd_y = '0;
        repeat (3) @(negedge clk);
        check("reset_rd_colour", int'(rd_colour), 0);
        check("reset_clear_done", int'(clear_done), 0);
        rst = 1'b0;
        @(negedge clk);

        // full clear to 3'b010 and handshake
        do_clear(3'b010, 0, cyc);
        check("clear_latency_in_range", int'(cyc - 1 >= 19200 && cyc - 1 <= 19201), 1);
        check("clear_done_high", int'(clear_done), 1);
        @(negedge clk);
        check("clear_done_held", int'(clear_done), 1);
        clear_start = 1'b0;
        @(negedge clk);
        check("clear_done_drop", int'(clear_done), 0);
        read_px(0, 0, c);     check("clear_px_0_0", int'(c), 3'b010);
        read_px(159, 119, c); check("clear_px_159_119", int'(c), 3'b010);

        // single plot and neighbour
        plot(80, 60, 3'b101);
        @(negedge clk);
        read_px(80, 60, c); check("plot_80_60", int'(c), 3'b101);
        read_px(81, 60, c); check("neighbour_81_60", int'(c), 3'b010);

        // off-screen plots
        plot(160, 0, 3'b111);
        plot(0, 120, 3'b111);
        plot(255, 127, 3'b111);
        repeat (2) @(negedge clk);
        read_px(0, 1, c);   check("alias_0_1", int'(c), 3'b010);
        read_px(200, 5, c); check("offscreen_read", int'(c), 0);
`ifdef FB_PLOT_STATS_EN
        check("lit_plot_count_1", int'(plot_count), 1);
        check("lit_drop_count_3", int'(drop_count), 3);
`endif

        // clear with plots streamed mid-clear, then sweep the screen
        do_clear(3'b010, 50, cyc);
        clear_start = 1'b0;
        @(negedge clk);
`ifdef FB_PLOT_STATS_EN
        check("lit_drop_count_53", int'(drop_count), 53);
`endif
        bad = 0;
        for (int a = 0; a < NPIX; a++) begin
            read_px(a % W, a / W, c);
            if (c != 3'b010) bad++;
        end
        check("uniform_after_clear", bad, 0);

        // abort a clear with reset
        plot(159, 119, 3'b110);
        repeat (2) @(negedge clk);
        clear_colour = 3'b001;
        clear_start  = 1'b1;
        in_clear     = 1;
        repeat (1000) @(negedge clk);
        rst = 1'b1; clear_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 980; a++) model_mem[a] = 3'b001;
        for (int a = 980; a < 1020; a++) model_known[a] = 0;
        in_clear = 0;
        check("abort_clear_done", int'(clear_done), 0);
`ifdef FB_PLOT_STATS_EN
        check("abort_plot_count", int'(plot_count), 0);
        check("abort_drop_count", int'(drop_count), 0);
`endif
        read_px(0, 0, c);     check("abort_px_0", int'(c), 3'b001);
        read_px(159, 119, c); check("abort_px_last", int'(c), 3'b110);

        // circle r=30 centred at (80,60)
        ox = 30; oy = 0; crit = 1 - 30;
        while (oy <= ox) begin
            qx.push_back(80 + ox); qy.push_back(60 + oy);
            qx.push_back(80 + oy); qy.push_back(60 + ox);
            qx.push_back(80 - ox); qy.push_back(60 + oy);
            qx.push_back(80 - oy); qy.push_back(60 + ox);
            qx.push_back(80 - ox); qy.push_back(60 - oy);
            qx.push_back(80 - oy); qy.push_back(60 - ox);
            qx.push_back(80 + ox); qy.push_back(60 - oy);
            qx.push_back(80 + oy); qy.push_back(60 - ox);
            oy++;
            if (crit <= 0) crit += 2 * oy + 1;
            else begin
                ox--;
                crit += 2 * (oy - ox) + 1;
            end
        end
        for (int i = 0; i < qx.size(); i++) begin
            vga_x = 8'(qx[i]); vga_y = 7'(qy[i]); vga_colour = 3'b111; vga_plot = 1'b1;
            @(negedge clk);
        end
        vga_plot = 1'b0;
        repeat (2) @(negedge clk);
`ifdef FB_PLOT_STATS_EN
        check("circle_plot_count", int'(plot_count), qx.size());
`endif
        bad = 0;
        for (int i = 0; i < qx.size(); i++) begin
            read_px(qx[i], qy[i], c);
            if (c != 3'b111) bad++;
        end
        check("circle_readback", bad, 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
